// File: rtl/prv_trap_pkg.sv
// Shared types and constants for the privilege-block trap controller.
package prv_trap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2,
    INSERT = 2'd3
  } trap_state_t;

  typedef enum logic {
    TRAP = 1'b0,
    RET  = 1'b1
  } trap_kind_t;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/prv_prio_enc.sv
// Lowest-index-wins priority encoder; valid is high when any request bit is set.
module prv_prio_enc #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Trap controller: arbitrates exceptions, maskable interrupts and mret, then
// sequences each one through drain / commit / redirect.
module prv_trap_ctrl
  import prv_trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_EXC  = 16,
  parameter int NUM_IRQ  = 8,
  parameter int IRQ_BASE = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_EXC-1:0] exc_vec,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_in,
  input  logic               ret,
  input  logic               pipe_clear,
  output logic               intr,
  output logic               csr_we,
  output logic               ret_o,
  output logic [XLEN-1:0]    cause_o,
  output logic [XLEN-1:0]    epc_o,
  output logic [XLEN-1:0]    tval_o,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic [NUM_IRQ-1:0] irq_pending
);

  localparam int EW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_t        state_reg, state_next;
  trap_kind_t         kind_reg;
  logic [XLEN-1:0]    cause_reg, epc_reg, tval_reg, target_reg;
  logic [NUM_IRQ-1:0] irq_pending_reg;

  logic               exc_valid, irq_valid;
  logic [EW-1:0]      exc_idx;
  logic [IW-1:0]      irq_idx;
  logic               take_exc, take_irq, take_ret;
  logic [XLEN-2:0]    irq_code;
  logic [XLEN-1:0]    vec_base, vec_off, trap_target;

  prv_prio_enc #(.N(NUM_EXC)) u_exc_enc (
    .req   (exc_vec),
    .valid (exc_valid),
    .idx   (exc_idx)
  );

  prv_prio_enc #(.N(NUM_IRQ)) u_irq_enc (
    .req   (irq_pending_reg),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  always_comb begin
    state_next = state_reg;
    take_exc   = 1'b0;
    take_irq   = 1'b0;
    take_ret   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (exc_valid) begin
          take_exc   = 1'b1;
          state_next = DRAIN;
        end else if (gie && irq_valid) begin
          take_irq   = 1'b1;
          state_next = DRAIN;
        end else if (ret) begin
          take_ret   = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_clear) state_next = (kind_reg == RET) ? INSERT : COMMIT;
      end
      COMMIT:  state_next = INSERT;
      INSERT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vectored offset uses the cause code with the interrupt bit stripped.
  assign irq_code    = (XLEN-1)'(IRQ_BASE) + (XLEN-1)'(irq_idx);
  assign vec_base    = {mtvec[XLEN-1:2], 2'b00};
  assign vec_off     = {cause_reg[XLEN-3:0], 2'b00};
  assign trap_target = ((mtvec[1:0] == MTVEC_MODE_VECTORED) && cause_reg[XLEN-1])
                       ? (vec_base + vec_off) : vec_base;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      kind_reg        <= TRAP;
      cause_reg       <= '0;
      epc_reg         <= '0;
      tval_reg        <= '0;
      target_reg      <= '0;
      irq_pending_reg <= '0;
    end else begin
      state_reg       <= state_next;
      irq_pending_reg <= irq_in & irq_en;
      if (take_exc) begin
        kind_reg  <= TRAP;
        cause_reg <= XLEN'(exc_idx);
        epc_reg   <= exc_pc;
        tval_reg  <= exc_tval;
      end else if (take_irq) begin
        kind_reg  <= TRAP;
        cause_reg <= {1'b1, irq_code};
        epc_reg   <= exc_pc;
        tval_reg  <= '0;
      end else if (take_ret) begin
        kind_reg  <= RET;
      end
      if (state_reg == COMMIT) begin
        target_reg <= trap_target;
      end else if ((state_reg == DRAIN) && pipe_clear && (kind_reg == RET)) begin
        target_reg <= mepc_in;
      end
    end
  end

  assign intr        = (state_reg != IDLE);
  assign csr_we      = (state_reg == COMMIT) && (kind_reg == TRAP);
  assign ret_o       = (state_reg == INSERT) && (kind_reg == RET);
  assign insert_pc   = (state_reg == INSERT);
  assign priv_pc     = target_reg;
  assign cause_o     = cause_reg;
  assign epc_o       = epc_reg;
  assign tval_o      = tval_reg;
  assign irq_pending = irq_pending_reg;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Scoreboard bench for prv_trap_ctrl: directed stimulus pushes expected
// CSR-commit / redirect events; a negedge monitor pops and compares them.
module tb_prv_trap_ctrl;

  logic        CLK;
  logic        nRST;
  logic [15:0] exc_vec;
  logic [31:0] exc_pc, exc_tval;
  logic [7:0]  irq_in, irq_en;
  logic        gie;
  logic [31:0] mtvec, mepc_in;
  logic        ret, pipe_clear;
  logic        intr, csr_we, ret_o, insert_pc;
  logic [31:0] cause_o, epc_o, tval_o, priv_pc;
  logic [7:0]  irq_pending;

  prv_trap_ctrl #(.XLEN(32), .NUM_EXC(16), .NUM_IRQ(8), .IRQ_BASE(16)) dut (
    .CLK(CLK), .nRST(nRST), .exc_vec(exc_vec), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .irq_in(irq_in), .irq_en(irq_en), .gie(gie), .mtvec(mtvec), .mepc_in(mepc_in),
    .ret(ret), .pipe_clear(pipe_clear), .intr(intr), .csr_we(csr_we), .ret_o(ret_o),
    .cause_o(cause_o), .epc_o(epc_o), .tval_o(tval_o), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .irq_pending(irq_pending)
  );

  typedef struct {
    bit          ins;
    int          cyc;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] pc;
    bit          rt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_zero = 0;
  bit   chk_intr = 0;
  bit   chk_end  = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: all comparisons live here so the counters have a single writer.
  initial forever begin
    @(negedge CLK);
    if (chk_zero) begin
      check("rst_intr", 32'(intr), 32'd0);
      check("rst_csr_we", 32'(csr_we), 32'd0);
      check("rst_ret_o", 32'(ret_o), 32'd0);
      check("rst_insert_pc", 32'(insert_pc), 32'd0);
      check("rst_cause", cause_o, 32'd0);
      check("rst_epc", epc_o, 32'd0);
      check("rst_tval", tval_o, 32'd0);
      check("rst_priv_pc", priv_pc, 32'd0);
      check("rst_irq_pending", 32'(irq_pending), 32'd0);
    end
    if (chk_intr) check("drain_intr", 32'(intr), 32'd1);
    if (csr_we || insert_pc) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, insert_pc, csr_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("event %s cyc=%0d cause=%h epc=%h tval=%h pc=%h ret_o=%0d",
                 insert_pc ? "insert" : "commit", cyc, cause_o, epc_o, tval_o, priv_pc, ret_o);
        check("event_kind", 32'(insert_pc), 32'(e.ins));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("intr_in_event", 32'(intr), 32'd1);
        if (e.ins) begin
          check("priv_pc", priv_pc, e.pc);
          check("ret_o", 32'(ret_o), 32'(e.rt));
        end else begin
          check("cause_o", cause_o, e.cause);
          check("epc_o", epc_o, e.epc);
          check("tval_o", tval_o, e.tval);
          check("ret_o_in_commit", 32'(ret_o), 32'd0);
        end
      end
    end
    if (chk_end) check("scoreboard_empty", 32'(sb.size()), 32'd0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic push_trap(input int c, input logic [31:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval, input logic [31:0] pc);
    exp_t e;
    e = '{ins: 1'b0, cyc: c, cause: cause, epc: epc, tval: tval, pc: 32'd0, rt: 1'b0};
    sb.push_back(e);
    e = '{ins: 1'b1, cyc: c + 1, cause: 32'd0, epc: 32'd0, tval: 32'd0, pc: pc, rt: 1'b0};
    sb.push_back(e);
  endtask

  initial begin
    int c;
    nRST = 0; exc_vec = '0; exc_pc = '0; exc_tval = '0; irq_in = '0; irq_en = '0;
    gie = 0; mtvec = '0; mepc_in = '0; ret = 0; pipe_clear = 1;

    // Reset state
    step(2);
    chk_zero = 1;
    step(1);
    chk_zero = 0;
    nRST = 1;
    step(2);

    // Exception arbitration: lowest set bit of 0x24 is 2
    mtvec = 32'h0000_1001; exc_pc = 32'h100; exc_tval = 32'hDEAD; exc_vec = 16'h0024;
    c = cyc;
    push_trap(c + 2, 32'd2, 32'h100, 32'hDEAD, 32'h0000_1000);
    step(3);
    exc_vec = '0;
    step(2);

    // Vectored interrupt: line 2 -> cause 18, target base + 18*4
    mtvec = 32'h8000_0001; exc_pc = 32'h200; gie = 1; irq_en = 8'hFF; irq_in = 8'h0C;
    c = cyc;
    push_trap(c + 3, 32'h8000_0012, 32'h200, 32'd0, 32'h8000_0048);
    step(4);
    irq_in = '0;
    step(3);

    // Exception beats an already-pending interrupt, then the interrupt follows
    gie = 0; irq_in = 8'h01;
    step(1);
    gie = 1; exc_vec = 16'h0010; exc_pc = 32'h300; exc_tval = 32'h44;
    c = cyc;
    push_trap(c + 2, 32'd4, 32'h300, 32'h44, 32'h8000_0000);
    push_trap(c + 6, 32'h8000_0010, 32'h300, 32'd0, 32'h8000_0040);
    step(3);
    exc_vec = '0;
    step(4);
    irq_in = '0; gie = 0;
    step(3);

    // Drain wait: five cycles without pipe_clear
    mtvec = 32'h0000_2000; pipe_clear = 0; exc_vec = 16'h0001; exc_pc = 32'h400; exc_tval = 32'h55;
    c = cyc;
    push_trap(c + 6, 32'd0, 32'h400, 32'h55, 32'h0000_2000);
    step(1);
    chk_intr = 1;
    step(4);
    chk_intr = 0; pipe_clear = 1;
    step(2);
    exc_vec = '0;
    step(2);

    // Return: redirect to mepc, no CSR write strobe
    mtvec = 32'h0000_3000; mepc_in = 32'h2000; ret = 1;
    c = cyc;
    begin
      exp_t e;
      e = '{ins: 1'b1, cyc: c + 2, cause: 32'd0, epc: 32'd0, tval: 32'd0, pc: 32'h2000, rt: 1'b1};
      sb.push_back(e);
    end
    step(1);
    ret = 0;
    step(3);

    // Reset while in COMMIT: no redirect may follow
    exc_vec = 16'h8000; exc_pc = 32'h500; exc_tval = 32'h66;
    c = cyc;
    begin
      exp_t e;
      e = '{ins: 1'b0, cyc: c + 2, cause: 32'd15, epc: 32'h500, tval: 32'h66, pc: 32'd0, rt: 1'b0};
      sb.push_back(e);
    end
    step(2);
    nRST = 0; exc_vec = '0;
    step(1);
    nRST = 1; chk_zero = 1;
    step(1);
    chk_zero = 0;
    step(4);

    chk_end = 1;
    step(1);
    chk_end = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prv_trap_ctrl.md
# prv_trap_ctrl

Parametrised trap controller that sits inside the privilege block, between the pipeline hazard unit and the machine-mode CSR file. It arbitrates `NUM_EXC` synchronous exception flags and `NUM_IRQ` maskable level interrupts, and handles `mret`. It sequences each trap or return through a drain / commit / redirect state machine, producing a one-cycle CSR-update strobe and a one-cycle PC-insert pulse. It generalises the fixed timer/soft/external interrupt set to N channels and adds vectored-mode target generation.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_EXC`, 16, exception flag count; index = mcause exception code.
- `NUM_IRQ`, 8, interrupt line count; index i maps to cause code `IRQ_BASE+i`.
- `IRQ_BASE`, 16, first interrupt cause code.

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  reset; synchronous, active-low.
- `exc_vec`  in  NUM_EXC  exception flags; held by the pipeline until `insert_pc`.
- `exc_pc`  in  XLEN  PC of the faulting instruction.
- `exc_tval`  in  XLEN  bad address / instruction bits.
- `irq_in`  in  NUM_IRQ  level interrupt lines.
- `irq_en`  in  NUM_IRQ  per-line enable (mie).
- `gie`  in  1  global interrupt enable (mstatus.MIE).
- `mtvec`  in  XLEN  trap vector; bits [1:0]==1 selects vectored mode.
- `mepc_in`  in  XLEN  current mepc, used as the return target.
- `ret`  in  1  mret reached the commit stage.
- `pipe_clear`  in  1  pipeline drained.
- `intr`  out  1  trap/return in progress; hazard unit must flush.
- `csr_we`  out  1  one-cycle strobe to write mepc/mcause/mtval/mstatus.
- `ret_o`  out  1  one-cycle strobe to restore mstatus on mret.
- `cause_o`  out  XLEN  latched mcause; bit XLEN-1 = interrupt.
- `epc_o`  out  XLEN  latched epc.
- `tval_o`  out  XLEN  latched tval; 0 for interrupts.
- `insert_pc`  out  1  one-cycle redirect pulse.
- `priv_pc`  out  XLEN  redirect target, valid while `insert_pc` is high.
- `irq_pending`  out  NUM_IRQ  `irq_in & irq_en`, registered (mip view).

## Operation
States: IDLE, DRAIN, COMMIT, INSERT.

Outputs are Moore-decoded from the state and latched registers:
- `intr` = 1 in DRAIN, COMMIT and INSERT.
- `csr_we` = 1 in COMMIT, trap kind only.
- `ret_o` = 1 in INSERT, return kind only.
- `insert_pc` = 1 in INSERT.

IDLE arbitration, evaluated each cycle. Priority order is exception > interrupt > ret.
- **Exception:** any `exc_vec` bit set. Lowest set index wins. Latch `cause_o={0,idx}`, `epc_o=exc_pc`, `tval_o=exc_tval`, kind=trap; go to DRAIN.
- **Interrupt:** `gie` high and `irq_pending` nonzero. Lowest index i wins. Latch `cause_o={1,IRQ_BASE+i}`, `epc_o=exc_pc`, `tval_o=0`, kind=trap; go to DRAIN.
- **Return:** `ret` high. Latch kind=ret; go to DRAIN.

Transitions:
- DRAIN: stay until `pipe_clear`=1. Then trap kind goes to COMMIT; ret kind goes to INSERT.
- COMMIT: unconditional, to INSERT.
- INSERT: unconditional, to IDLE.

Redirect target (`priv_pc`):
- Ret kind: `mepc_in`.
- Trap with `mtvec[1:0]`==1 and interrupt cause: `{mtvec[XLEN-1:2],2'b00} + (code<<2)`, truncated to XLEN.
- All other traps: `{mtvec[XLEN-1:2],2'b00}`.
- The target is computed in COMMIT (DRAIN for ret) and registered.

Event handling outside IDLE:
- New exceptions, interrupts and `ret` are ignored and do not queue.
- Interrupts are level-sensitive and stay visible in `irq_pending`.
- Exception flags are re-evaluated after return to IDLE.

Reset: `nRST`=0 at any rising edge forces IDLE and clears every output and latched register to 0, including mid-sequence. No partial `csr_we` or `insert_pc` pulse is produced.

## Timing
- `irq_pending` lags `irq_in`/`irq_en` by 1 cycle. Arbitration uses the registered value.
- Exception seen in IDLE at cycle 0 with `pipe_clear` already high:
  - `intr` high from cycle 1.
  - `csr_we` at cycle 2.
  - `insert_pc` at cycle 3.
  - IDLE at cycle 4.
- Minimum trap latency is 3 cycles; each cycle of `pipe_clear`=0 adds one.
- Ret latency is a minimum of 2 cycles (`insert_pc` and `ret_o` together).
- `cause_o`, `epc_o` and `tval_o` are stable from DRAIN entry until the next arbitration.

## Structure
- `prv_trap_pkg` holds:
  - the `trap_state_t` enum (IDLE/DRAIN/COMMIT/INSERT);
  - the `trap_kind_t` enum (TRAP/RET);
  - the `MTVEC_MODE_VECTORED` constant (2'b01).
- Sub-module `prv_prio_enc`: parametrised lowest-index priority encoder with `valid` and `$clog2(N)`-bit index outputs. It is instantiated twice, for exceptions and interrupts.

## Test plan
- **Exception arbitration:** `exc_vec`=16'h0024, `exc_pc`=32'h100, `pipe_clear`=1 → cycle 2 `csr_we`=1 with `cause_o`=2 and `epc_o`=32'h100; cycle 3 `insert_pc`=1 with `priv_pc`=`mtvec`&~3.
- **Vectored interrupt:** `gie`=1, `irq_en`=8'hFF, `irq_in`=8'h0C, `mtvec`=32'h8000_0001 → `cause_o`=32'h8000_0012, `priv_pc`=32'h8000_0048.
- **Exception priority:** exception and enabled interrupt in the same cycle → exception cause taken. After INSERT with `irq_in` held, the interrupt trap follows.
- **Drain wait:** `pipe_clear` held 0 for 5 cycles in DRAIN → `intr` held high and no `csr_we`. `insert_pc` comes exactly 2 cycles after `pipe_clear` rises.
- **Return:** `ret`=1, `mepc_in`=32'h2000 → `insert_pc` and `ret_o` together with `priv_pc`=32'h2000, and `csr_we` never asserted.
- **Mid-sequence reset:** `nRST`=0 while in COMMIT → next cycle is IDLE with every output 0, and no `insert_pc` follows.
